lut_slicem_cfg: RTL

Parametrised, writable K-input LUT cell for the SLICEM-style CLB. It loads its full configuration (per-input routing selects, mode bits and LUT truth table) over a serial chain while `prgm_b`=0, and signals completion so that the next cell in the CLB can start loading. In user mode (`prgm_b`=1) it routes K of NIN fabric inputs into the LUT address, and drives a combinational or registered output. When RAM mode is configured, the LUT can also be written as distributed RAM.

---
 rtl/lut_slicem_cfg_if.sv | 29 ++
 rtl/lut_slicem_cfg.sv | 109 ++++++++++
 2 files changed

// File: rtl/lut_slicem_cfg_if.sv
// Bus bundle for one writable LUT cell: configuration chain, fabric
// routing inputs, RAM write port and the exported mode bits.
interface lut_slicem_cfg_if #(
    parameter int NIN = 24
);
    logic           prgm_b;
    logic           cfg_en;
    logic           cfg_din;
    logic           cfg_done;
    logic [NIN-1:0] route_in;
    logic           we;
    logic           gwe;
    logic           wdata;
    logic           lut_out;
    logic           ram_en;
    logic           carry_sel;

    // The LUT cell itself
    modport slave (
        input  prgm_b, cfg_en, cfg_din, route_in, we, gwe, wdata,
        output cfg_done, lut_out, ram_en, carry_sel
    );

    // Whatever drives the cell (configuration controller, fabric, bench)
    modport master (
        output prgm_b, cfg_en, cfg_din, route_in, we, gwe, wdata,
        input  cfg_done, lut_out, ram_en, carry_sel
    );
endinterface

// File: rtl/lut_slicem_cfg.sv
// Writable K-input LUT cell for a SLICEM-style CLB. The whole configuration
// (truth table, mode bits, per-input routing selects) is loaded through a
// serial shift chain while prgm_b is low. In user mode the truth-table part
// of that same chain is the LUT storage, and doubles as distributed RAM.
module lut_slicem_cfg #(
    parameter int K    = 4,
    parameter int NIN  = 24,
    parameter int SELW = 5
) (
    input  logic              CLK,
    input  logic              reset_b,
    lut_slicem_cfg_if.slave   bus
);

    localparam int DEPTH     = 1 << K;
    localparam int CFG_LEN   = DEPTH + 3 + K * SELW;
    localparam int CNTW      = $clog2(CFG_LEN + 1);
    localparam int RAM_BIT   = DEPTH;
    localparam int CARRY_BIT = DEPTH + 1;
    localparam int FF_BIT    = DEPTH + 2;
    localparam int SEL_BASE  = DEPTH + 3;

    logic [CFG_LEN-1:0] r_chain;
    logic [CNTW-1:0]    r_bitCnt;
    logic               r_cfgDone;
    logic               r_lutQ;

    logic               w_shift;
    logic               w_active;
    logic               w_ramWrite;
    logic               w_lutComb;
    logic [K-1:0]       w_addr;
    logic [DEPTH-1:0]   w_table;
    logic [DEPTH-1:0]   w_tableNext;
    logic [SELW-1:0]    w_sel [K];

    // Loading only happens in the config phase, when upstream is finished,
    // and only until this cell has its full bitstream; after that the chain
    // is frozen until the next reset.
    assign w_shift    = ~bus.prgm_b & bus.cfg_en & ~r_cfgDone;
    assign w_active   = bus.prgm_b & r_cfgDone;
    assign w_ramWrite = w_active & r_chain[RAM_BIT] & bus.we & bus.gwe;
    assign w_table    = r_chain[DEPTH-1:0];

    for (genvar j = 0; j < K; j++) begin : g_sel
        assign w_sel[j] = r_chain[SEL_BASE + j*SELW +: SELW];
    end

    // Route K of the fabric inputs onto the LUT address; selects that point
    // past the last fabric input read as a constant 0 instead of X.
    always_comb begin
        w_addr = '0;
        for (int j = 0; j < K; j++) begin
            if (int'(w_sel[j]) < NIN) begin
                w_addr[j] = bus.route_in[w_sel[j]];
            end
        end
    end

    // Table image with the addressed entry replaced by the RAM write data.
    always_comb begin
        w_tableNext         = w_table;
        w_tableNext[w_addr] = bus.wdata;
    end

    assign w_lutComb = w_active & w_table[w_addr];

    // Configuration chain: serial load, then in-place RAM writes to the
    // truth-table field once the cell is in user mode.
    always_ff @(posedge CLK or negedge reset_b) begin
        if (!reset_b) begin
            r_chain <= '0;
        end else if (w_shift) begin
            r_chain <= {bus.cfg_din, r_chain[CFG_LEN-1:1]};
        end else if (w_ramWrite) begin
            r_chain[DEPTH-1:0] <= w_tableNext;
        end
    end

    // Bit counter and sticky done flag; done rises on the edge that takes
    // in the last configuration bit and the counter then holds.
    always_ff @(posedge CLK or negedge reset_b) begin
        if (!reset_b) begin
            r_bitCnt  <= '0;
            r_cfgDone <= 1'b0;
        end else if (w_shift) begin
            r_bitCnt <= r_bitCnt + 1'b1;
            if (r_bitCnt == CNTW'(CFG_LEN - 1)) begin
                r_cfgDone <= 1'b1;
            end
        end
    end

    // Output register, updated only while the cell is in user mode so that
    // dropping back to the config phase freezes the last registered value.
    always_ff @(posedge CLK or negedge reset_b) begin
        if (!reset_b) begin
            r_lutQ <= 1'b0;
        end else if (w_active) begin
            r_lutQ <= w_lutComb;
        end
    end

    assign bus.cfg_done  = r_cfgDone;
    assign bus.lut_out   = r_chain[FF_BIT] ? r_lutQ : w_lutComb;
    assign bus.ram_en    = r_chain[RAM_BIT];
    assign bus.carry_sel = r_chain[CARRY_BIT];

endmodule
